// File: rtl/scheduler.sv
// scheduler: picks read/write FIFO requests or refresh and hands single commands to the sequencer
module scheduler (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        raf_empty_ni,
    input  logic        raf_block_i,
    output logic        raf_read_o,
    input  logic [22:0] raf_addr_i,
    input  logic        wf_empty_ni,
    input  logic        wf_block_i,
    output logic        wf_read_o,
    input  logic [22:0] wf_addr_i,
    output logic        cmd_start_o,
    output logic        cmd_read_o,
    output logic        cmd_last_o,
    output logic [1:0]  cmd_bank_o,
    output logic [12:0] cmd_row_o,
    output logic [7:0]  cmd_col_o,
    input  logic        ctl_exec_i,
    input  logic        ctl_active_i,
    input  logic        rfc_req_i,
    output logic        rfc_ack_o,
    input  logic        rfc_end_i
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, REFRESH} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_pop_r;
    logic        w_pop_w;
    logic        w_ack;
    logic [22:0] r_addr;
    logic        r_blk;
    logic        r_rd;
    logic        r_pend;
    logic [22:0] r_cmd_addr;
    logic        r_cmd_read;
    logic        r_cmd_last;

    // next state and pop/grant decisions; refresh beats read beats write, nothing while the sequencer is busy
    always_comb begin
        w_next  = r_state;
        w_pop_r = 1'b0;
        w_pop_w = 1'b0;
        w_ack   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!ctl_exec_i) begin
                    if (rfc_req_i && !ctl_active_i) begin
                        w_ack  = 1'b1;
                        w_next = REFRESH;
                    end else if (enable_i && raf_empty_ni) begin
                        w_pop_r = 1'b1;
                        w_next  = FETCH;
                    end else if (enable_i && wf_empty_ni) begin
                        w_pop_w = 1'b1;
                        w_next  = FETCH;
                    end
                end
            end
            FETCH:   w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = ctl_exec_i ? WAIT : IDLE;
            REFRESH: w_next = rfc_end_i ? IDLE : REFRESH;
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock_i) begin
        if (reset_i)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // request latch, pending-refresh flag and command output registers (held between commands)
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_addr     <= '0;
            r_blk      <= 1'b0;
            r_rd       <= 1'b0;
            r_pend     <= 1'b0;
            r_cmd_addr <= '0;
            r_cmd_read <= 1'b0;
            r_cmd_last <= 1'b0;
        end else begin
            if (w_pop_r || w_pop_w) begin
                r_addr <= w_pop_r ? raf_addr_i : wf_addr_i;
                r_blk  <= w_pop_r ? raf_block_i : wf_block_i;
                r_rd   <= w_pop_r;
            end
            r_pend <= (w_ack || r_state == REFRESH) ? 1'b0 : (r_pend | rfc_req_i);
            if (r_state == FETCH) begin
                r_cmd_addr <= r_addr;
                r_cmd_read <= r_rd;
                r_cmd_last <= ~r_blk | r_pend | rfc_req_i;
            end
        end
    end

    // strobes are suppressed while reset is held so an abandoned request emits nothing
    assign raf_read_o  = w_pop_r & ~reset_i;
    assign wf_read_o   = w_pop_w & ~reset_i;
    assign rfc_ack_o   = w_ack & ~reset_i;
    assign cmd_start_o = (r_state == ISSUE) & ~reset_i;
    assign cmd_read_o  = r_cmd_read;
    assign cmd_last_o  = r_cmd_last;
    assign cmd_bank_o  = r_cmd_addr[22:21];
    assign cmd_row_o   = r_cmd_addr[20:8];
    assign cmd_col_o   = r_cmd_addr[7:0];
endmodule

// File: tb/tb_scheduler.sv
// tb_scheduler: transaction-level scoreboard bench for scheduler with FIFO, sequencer and refresh models
module tb_scheduler;
    logic        clock_i = 1'b0;
    logic        reset_i, enable_i;
    logic        raf_empty_ni, raf_block_i, wf_empty_ni, wf_block_i;
    logic [22:0] raf_addr_i, wf_addr_i;
    logic        raf_read_o, wf_read_o, cmd_start_o, cmd_read_o, cmd_last_o, rfc_ack_o;
    logic [1:0]  cmd_bank_o;
    logic [12:0] cmd_row_o;
    logic [7:0]  cmd_col_o;
    logic        ctl_exec_i, ctl_active_i, rfc_req_i, rfc_end_i;

    always #5 clock_i = ~clock_i;

    scheduler dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .raf_empty_ni(raf_empty_ni), .raf_block_i(raf_block_i), .raf_read_o(raf_read_o), .raf_addr_i(raf_addr_i),
        .wf_empty_ni(wf_empty_ni), .wf_block_i(wf_block_i), .wf_read_o(wf_read_o), .wf_addr_i(wf_addr_i),
        .cmd_start_o(cmd_start_o), .cmd_read_o(cmd_read_o), .cmd_last_o(cmd_last_o),
        .cmd_bank_o(cmd_bank_o), .cmd_row_o(cmd_row_o), .cmd_col_o(cmd_col_o),
        .ctl_exec_i(ctl_exec_i), .ctl_active_i(ctl_active_i),
        .rfc_req_i(rfc_req_i), .rfc_ack_o(rfc_ack_o), .rfc_end_i(rfc_end_i)
    );

    typedef struct {
        logic        rd;
        logic        blk;
        logic [22:0] addr;
        int          cyc;
    } exp_t;

    logic [23:0] raf_q[$];
    logic [23:0] wf_q[$];
    exp_t        infl[$];

    int   n_cmp = 0, n_err = 0, cyc = 0;
    int   npush = 0, npop = 0, npop_w = 0, nstart = 0, nack = 0, nabort = 0;
    int   exec_cnt = 0, end_cnt = 0, rfc_age = 0;
    int   last_pop_cyc = -1, last_ack_cyc = -1, last_end_cyc = -1;
    logic refreshing = 0, next_act = 0, act_upd = 0, exec_hold = 0;
    logic rfc_kick = 0, rfc_rand = 0, en_want = 0, rst_want = 1, prev_rst = 0;
    logic last_last = 0, last_rd = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic w, input logic blk, input logic [22:0] a);
        if (w) wf_q.push_back({blk, a});
        else raf_q.push_back({blk, a});
        npush++;
    endtask

    // observe one cycle of DUT outputs against the transaction model
    task automatic monitor();
        exp_t e;
        logic x;
        cyc++;
        if (reset_i) begin
            check("rst_strobe", 32'({raf_read_o, wf_read_o, cmd_start_o, rfc_ack_o}), 0);
            if (prev_rst)
                check("rst_regs", 32'({cmd_read_o, cmd_last_o, cmd_bank_o, cmd_row_o, cmd_col_o}), 0);
            nabort += infl.size();
            infl.delete();
            refreshing = 0;
            exec_cnt = 0;
            act_upd = 0;
            rfc_age = 0;
            prev_rst = 1;
        end else begin
            prev_rst = 0;
            if (raf_read_o || wf_read_o) begin
                check("pop_excl", 32'(raf_read_o && wf_read_o), 0);
                check("pop_en", 32'(enable_i), 1);
                check("pop_exec", 32'(ctl_exec_i), 0);
                check("pop_busy", 32'(infl.size() != 0 || refreshing), 0);
                check("pop_rfc", 32'(rfc_req_i && !ctl_active_i), 0);
                if (raf_read_o) begin
                    check("raf_nonempty", 32'(raf_empty_ni), 1);
                    if (raf_q.size() > 0) begin
                        e.rd = 1; {e.blk, e.addr} = raf_q.pop_front(); e.cyc = cyc + 2;
                        infl.push_back(e);
                    end
                end else begin
                    check("wf_nonempty", 32'(wf_empty_ni), 1);
                    check("wf_prio", 32'(raf_empty_ni), 0);
                    npop_w++;
                    if (wf_q.size() > 0) begin
                        e.rd = 0; {e.blk, e.addr} = wf_q.pop_front(); e.cyc = cyc + 2;
                        infl.push_back(e);
                    end
                end
                npop++;
                last_pop_cyc = cyc;
            end
            if (cmd_start_o) begin
                if (infl.size() == 0)
                    check("start_spurious", 32'(cmd_start_o), 0);
                else begin
                    e = infl.pop_front();
                    x = !e.blk || rfc_req_i;
                    check("start_lat", 32'(cyc), 32'(e.cyc));
                    check("start_rd", 32'(cmd_read_o), 32'(e.rd));
                    check("start_bank", 32'(cmd_bank_o), 32'(e.addr[22:21]));
                    check("start_row", 32'(cmd_row_o), 32'(e.addr[20:8]));
                    check("start_col", 32'(cmd_col_o), 32'(e.addr[7:0]));
                    check("start_last", 32'(cmd_last_o), 32'(x));
                end
                nstart++;
                last_last = cmd_last_o;
                last_rd = cmd_read_o;
                exec_cnt = $urandom_range(0, 4);
                next_act = !cmd_last_o;
                act_upd = 1;
            end else if (infl.size() > 0 && cyc > infl[0].cyc) begin
                check("start_late", 32'(cyc), 32'(infl[0].cyc));
                void'(infl.pop_front());
            end
            if (refreshing && rfc_end_i) begin
                refreshing = 0;
                last_end_cyc = cyc;
            end
            if (rfc_ack_o) begin
                check("ack_req", 32'(rfc_req_i), 1);
                check("ack_act", 32'(ctl_active_i), 0);
                check("ack_exec", 32'(ctl_exec_i), 0);
                check("ack_busy", 32'(infl.size() != 0 || refreshing), 0);
                nack++;
                last_ack_cyc = cyc;
                refreshing = 1;
                end_cnt = $urandom_range(1, 5);
            end
            if (rfc_req_i && !refreshing) begin
                rfc_age++;
                if (rfc_age == 300) check("rfc_starved", 32'(rfc_age), 0);
            end else rfc_age = 0;
        end
    endtask

    // environment: FIFO heads, sequencer busy/row-open, refresh requester
    task automatic drive();
        reset_i = rst_want;
        if (rst_want) begin
            rfc_req_i = 0; ctl_exec_i = 0; ctl_active_i = 0; rfc_end_i = 0;
        end else begin
            if (exec_hold || exec_cnt > 0) begin
                ctl_exec_i = 1;
                if (exec_cnt > 0) exec_cnt--;
            end else begin
                ctl_exec_i = 0;
                if (act_upd) begin ctl_active_i = next_act; act_upd = 0; end
            end
            rfc_end_i = refreshing && end_cnt == 0;
            if (refreshing && end_cnt > 0) end_cnt--;
            if (refreshing) rfc_req_i = 0;
            else if (!rfc_req_i && infl.size() == 0 && (rfc_kick || (rfc_rand && $urandom_range(0, 19) == 0))) begin
                rfc_req_i = 1;
                rfc_kick = 0;
            end
            if (rfc_req_i && ctl_active_i && raf_q.size() == 0 && wf_q.size() == 0)
                push(0, 1'($urandom_range(0, 1)), 23'($urandom));
        end
        enable_i = en_want || (rfc_req_i && ctl_active_i);
        raf_empty_ni = raf_q.size() != 0;
        {raf_block_i, raf_addr_i} = raf_q.size() != 0 ? raf_q[0] : 24'($urandom);
        wf_empty_ni = wf_q.size() != 0;
        {wf_block_i, wf_addr_i} = wf_q.size() != 0 ? wf_q[0] : 24'($urandom);
    endtask

    task automatic step();
        @(negedge clock_i);
        monitor();
        @(posedge clock_i);
        #1;
        drive();
    endtask

    task automatic wait_start(input string tag, input int bound);
        int s = nstart;
        int k = 0;
        while (nstart == s && k < bound) begin step(); k++; end
        check(tag, 32'(nstart - s), 1);
    endtask

    initial begin
        int p, s;
        logic done;
        drive();
        repeat (3) step();
        rst_want = 0;
        step();
        // single read, final word: auto-precharge
        push(0, 0, {2'b01, 13'h132, 8'h23});
        en_want = 1;
        wait_start("d31_start", 10);
        check("d31_pops", 32'(npop), 1);
        check("d31_rd", 32'(last_rd), 1);
        check("d31_last", 32'(last_last), 1);
        check("d31_bank", 32'(cmd_bank_o), 1);
        check("d31_row", 32'(cmd_row_o), 32'h132);
        check("d31_col", 32'(cmd_col_o), 32'h23);
        repeat (8) step();
        // burst word keeps the row open
        push(0, 1, {2'b01, 13'h132, 8'h23});
        wait_start("d32_start", 10);
        check("d32_pops", 32'(npop), 2);
        check("d32_last", 32'(last_last), 0);
        repeat (8) step();
        // write path at maximum address
        push(1, 0, {2'b10, 13'h1FFF, 8'hFF});
        wait_start("d33_start", 10);
        check("d33_wpops", 32'(npop_w), 1);
        check("d33_rd", 32'(last_rd), 0);
        check("d33_bank", 32'(cmd_bank_o), 2);
        check("d33_row", 32'(cmd_row_o), 32'h1FFF);
        check("d33_col", 32'(cmd_col_o), 32'hFF);
        repeat (8) step();
        // refresh and read arrive together with the row closed
        push(0, 0, 23'($urandom));
        rfc_kick = 1;
        wait_start("d34_start", 40);
        check("d34_ack", 32'(nack), 1);
        check("d34_order", 32'(last_ack_cyc >= 0 && last_ack_cyc < last_end_cyc && last_end_cyc < last_pop_cyc), 1);
        repeat (8) step();
        // sequencer held busy blocks further work
        push(0, 0, 23'($urandom));
        push(0, 0, 23'($urandom));
        wait_start("d35_start", 10);
        exec_hold = 1;
        p = npop; s = nstart;
        repeat (10) step();
        check("d35_pops", 32'(npop), 32'(p));
        check("d35_starts", 32'(nstart), 32'(s));
        exec_hold = 0;
        wait_start("d35_resume", 20);
        check("d35_pops_after", 32'(npop), 32'(p + 1));
        repeat (8) step();
        // disabled: no pops over 20 cycles
        en_want = 0;
        push(0, 0, 23'($urandom));
        p = npop;
        repeat (20) step();
        check("d36_nopop", 32'(npop), 32'(p));
        en_want = 1;
        wait_start("d36_resume", 10);
        repeat (8) step();
        // reset between pop and issue abandons the request
        push(0, 0, 23'($urandom));
        p = npop; s = nstart;
        for (int k = 0; k < 10 && npop == p; k++) step();
        check("rst_popped", 32'(npop), 32'(p + 1));
        rst_want = 1;
        repeat (3) step();
        rst_want = 0;
        repeat (6) step();
        check("rst_abort", 32'(nabort), 1);
        check("rst_nostart", 32'(nstart), 32'(s));
        // randomized traffic with refresh
        rfc_rand = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 16 == 0) en_want = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 7) == 0) push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 23'($urandom));
            step();
        end
        // drain everything
        rfc_rand = 0;
        en_want = 1;
        done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            step();
            done = raf_q.size() == 0 && wf_q.size() == 0 && infl.size() == 0 && !refreshing && !rfc_req_i;
        end
        check("drain", 32'(done), 1);
        check("pop_total", 32'(npop), 32'(npush));
        check("start_total", 32'(nstart), 32'(npop - nabort));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/scheduler.md
SCHEDULER -- requirements
Module: scheduler

Interface
REQ-001 SHALL have no parameters; address split is fixed: addr[22:21]=bank, addr[20:8]=row, addr[7:0]=col.
REQ-002 clock_i  in  1  single clock; all logic on rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 enable_i  in  1  high permits fetching new FIFO requests.
REQ-005 raf_empty_ni  in  1  read-address FIFO has an entry (active-high not-empty).
REQ-006 raf_block_i  in  1  current read entry is a non-final word of a burst (row stays open).
REQ-007 raf_read_o  out  1  one-cycle pop strobe to read-address FIFO.
REQ-008 raf_addr_i  in  23  read address at FIFO head.
REQ-009 wf_empty_ni, wf_block_i, wf_addr_i[22:0] in; wf_read_o out: write-FIFO equivalents of REQ-005..REQ-008.
REQ-010 cmd_start_o  out  1  one-cycle command strobe to the command sequencer.
REQ-011 cmd_read_o  out  1  1=read, 0=write; valid with cmd_start_o.
REQ-012 cmd_last_o  out  1  auto-precharge after access; valid with cmd_start_o.
REQ-013 cmd_bank_o[1:0], cmd_row_o[12:0], cmd_col_o[7:0]  out  command address fields.
REQ-014 ctl_exec_i  in  1  sequencer busy executing a command.
REQ-015 ctl_active_i  in  1  sequencer has a row open.
REQ-016 rfc_req_i  in  1  refresh request (level, held until acknowledged).
REQ-017 rfc_ack_o  out  1  one-cycle refresh grant.
REQ-018 rfc_end_i  in  1  one-cycle pulse: refresh finished.

Function
REQ-019 SHALL implement states IDLE, FETCH, ISSUE, WAIT, REFRESH.
REQ-020 IDLE priority when ctl_exec_i=0: refresh (REQ-025) > read > write; read/write taken only when enable_i=1.
REQ-021 IDLE, read selected (raf_empty_ni=1): assert raf_read_o for exactly one cycle, latch raf_addr_i and raf_block_i, go FETCH; write path identical using wf_* with cmd_read_o=0.
REQ-022 FETCH -> ISSUE next cycle; ISSUE asserts cmd_start_o for exactly one cycle with latched bank/row/col, cmd_read_o, and cmd_last_o = ~block (forced 1 if a refresh is pending); latency empty_n-sampled -> cmd_start_o = 2 cycles after raf_read_o.
REQ-023 After ISSUE go WAIT; WAIT lasts at least one cycle and returns to IDLE on the first cycle ctl_exec_i=0.
REQ-024 No FIFO SHALL be popped more than once per request; raf_read_o/wf_read_o never asserted outside IDLE and never simultaneously.
REQ-025 Refresh: when rfc_req_i=1 in IDLE with ctl_exec_i=0 and ctl_active_i=0, assert rfc_ack_o one cycle, go REFRESH; stay until rfc_end_i=1, then IDLE.
REQ-026 Refresh pending with ctl_active_i=1: continue issuing requests (REQ-021..023) with cmd_last_o forced 1 so the row closes; no new fetches after the row closes until refresh is acknowledged.
REQ-027 enable_i=0: no FIFO pops; refresh still serviced; an in-flight request completes.
REQ-028 cmd address outputs SHALL hold last issued values between commands.
REQ-029 Simultaneous rfc_req_i and raf_empty_ni in IDLE with row closed: refresh wins.

Reset
REQ-030 On reset_i=1 at a clock edge: state IDLE; raf_read_o, wf_read_o, cmd_start_o, cmd_read_o, cmd_last_o, rfc_ack_o =0; cmd_bank_o/row_o/col_o =0; latched block/pending flags cleared; reset mid-operation abandons any request without further strobes.

Verification
REQ-031 Reset, then raf_empty_ni=1, raf_block_i=0, raf_addr_i={2'b01,13'h132,8'h23}, bench clears empty_n on raf_read_o -> exactly one raf_read_o pulse, then one cmd_start_o with read=1, last=1, bank=1, row=0x132, col=0x23.
REQ-032 Same with raf_block_i=1 -> cmd_last_o=0, all else as REQ-031.
REQ-033 wf_empty_ni=1 only, addr {2'b10,13'h1FFF,8'hFF} -> one wf_read_o, cmd_start_o with read=0, bank=2, row=0x1FFF, col=0xFF.
REQ-034 rfc_req_i=1 and raf_empty_ni=1 together, ctl_active_i=0 -> rfc_ack_o first, no raf_read_o until rfc_end_i pulse, then read proceeds.
REQ-035 ctl_exec_i held 1 after a command -> no further pops/strobes until ctl_exec_i=0.
REQ-036 enable_i=0 with raf_empty_ni=1 for 20 cycles -> raf_read_o stays 0.
